sd_clock_ctrl: RTL

//  Sits directly upstream of the SD clock divider. Decodes host writes to the

---
 rtl/sd_clock_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sd_clock_ctrl.sv
// sd_clock_ctrl: decodes SDHCI Clock Control writes, sequences the divider
// reset/settle handshake and gates the card clock only while sd_clk is low.
module sd_clock_ctrl #(
    parameter int SETTLE_CYC = 16,
    parameter int DIV_W      = 8
) (
    input  logic             AXI_CLOCK,
    input  logic             AXI_RST,
    input  logic [15:0]      clk_ctrl_wdata,
    input  logic             clk_ctrl_we,
    input  logic             div_stable,
    input  logic             sd_clk_in,
    output logic             div_rst_n,
    output logic [DIV_W-1:0] DIVISOR,
    output logic             sd_clk_en,
    output logic [15:0]      clk_ctrl_rdata,
    output logic             busy
);

    localparam int               CNT_W    = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_STABLE  = 3'd2,
        ST_EN_WAIT = 3'd3,
        ST_RUN     = 3'd4,
        ST_GATE    = 3'd5,
        ST_RELOAD  = 3'd6
    } state_t;

    // N==0 behaves like N==1 so the card clock never stops on a zero select.
    function automatic logic [DIV_W-1:0] div_map(input logic [7:0] n);
        logic [DIV_W-1:0] d;
        if (n == 8'd0) begin
            d = {DIV_W{1'b0}};
        end else begin
            d = DIV_W'(n - 8'd1);
        end
        return d;
    endfunction

    state_t           state_r, state_s;
    logic [15:0]      ctrl_r;
    logic [7:0]       n_applied_r;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             stable_r;
    logic             load_s, ice_s, sce_s, chg_s;
    logic             div_on_s, stable_s, en_s, busy_s;
    logic             ctrl_unused_s;

    assign ice_s         = ctrl_r[0];
    assign sce_s         = ctrl_r[2];
    assign chg_s         = (ctrl_r[15:8] != n_applied_r);
    assign ctrl_unused_s = ^{ctrl_r[7:3], ctrl_r[1]};

    // Next-state logic; priority in every state is ICE=0, then freq change, then SCE.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        load_s  = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (ice_s) begin
                    state_s = ST_SETTLE;
                    load_s  = 1'b1;
                    cnt_s   = CNT_INIT;
                end else begin
                    state_s = ST_OFF;
                end
            end
            ST_SETTLE: begin
                if (!ice_s) begin
                    state_s = ST_OFF;
                end else if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else if (div_stable) begin
                    state_s = ST_STABLE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_STABLE: begin
                if (!ice_s) begin
                    state_s = ST_OFF;
                end else if (chg_s) begin
                    state_s = ST_RELOAD;
                    load_s  = 1'b1;
                end else if (sce_s) begin
                    state_s = ST_EN_WAIT;
                end else begin
                    state_s = ST_STABLE;
                end
            end
            ST_EN_WAIT: begin
                if (!ice_s || !sce_s || chg_s) begin
                    state_s = ST_STABLE;
                end else if (!sd_clk_in) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_EN_WAIT;
                end
            end
            ST_RUN: begin
                if (!ice_s || !sce_s || chg_s) begin
                    state_s = ST_GATE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_GATE: begin
                if (sd_clk_in) begin
                    state_s = ST_GATE;
                end else if (!ice_s) begin
                    state_s = ST_OFF;
                end else if (chg_s) begin
                    state_s = ST_RELOAD;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_STABLE;
                end
            end
            ST_RELOAD: begin
                state_s = ST_SETTLE;
                cnt_s   = CNT_INIT;
            end
            default: begin
                state_s = ST_OFF;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        div_on_s = (state_s != ST_OFF) && (state_s != ST_RELOAD);
        stable_s = (state_s == ST_STABLE) || (state_s == ST_EN_WAIT) ||
                   (state_s == ST_RUN)    || (state_s == ST_GATE);
        en_s     = (state_s == ST_RUN) || (state_s == ST_GATE);
        busy_s   = !((state_s == ST_OFF) || (state_s == ST_STABLE) || (state_s == ST_RUN));
    end

    // State, control shadow, divisor load and registered outputs.
    always_ff @(posedge AXI_CLOCK or negedge AXI_RST) begin
        if (!AXI_RST) begin
            state_r        <= ST_OFF;
            ctrl_r         <= 16'h0000;
            n_applied_r    <= 8'h00;
            cnt_r          <= {CNT_W{1'b0}};
            stable_r       <= 1'b0;
            DIVISOR        <= {DIV_W{1'b0}};
            div_rst_n      <= 1'b0;
            sd_clk_en      <= 1'b0;
            busy           <= 1'b0;
            clk_ctrl_rdata <= 16'h0000;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            stable_r  <= stable_s;
            div_rst_n <= div_on_s;
            sd_clk_en <= en_s;
            busy      <= busy_s;
            if (clk_ctrl_we) begin
                ctrl_r <= clk_ctrl_wdata;
            end else begin
                ctrl_r <= ctrl_r;
            end
            if (load_s) begin
                DIVISOR     <= div_map(ctrl_r[15:8]);
                n_applied_r <= ctrl_r[15:8];
            end else begin
                DIVISOR     <= DIVISOR;
                n_applied_r <= n_applied_r;
            end
            clk_ctrl_rdata <= {ctrl_r[15:8], 5'b00000, ctrl_r[2], stable_r, ctrl_r[0]};
        end
    end

endmodule
